// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Slave-side companion to the stack CPU. Before the CPU runs it fills an
// internal word RAM from a byte stream (16-bit length, then big-endian
// words). Once the load completes it raises cpu_run, answers the CPU's
// word-addressed bus from that RAM with one cycle of read latency, and
// captures OUT strobes into a small FIFO that drains over valid/ready.

module cpu_bus_responder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU memory bus
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        wr,
  output logic [15:0] rdata,
  // CPU OUT port
  input  logic [7:0]  leds,
  input  logic        lr,
  // boot byte stream
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  output logic        ld_ready,
  // run gate
  output logic        cpu_run,
  // OUT capture drain
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_overflow
);

  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DAT_HI = 3'd2,
    ST_DAT_LO = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Load sequencer state
  // ---------------------------------------------------------------------
  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] len_r;
  logic [15:0] len_next_s;
  logic [7:0]  held_r;
  logic [7:0]  held_next_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;
  logic        ld_ready_r;
  logic        cpu_run_r;

  logic        byte_take_s;
  logic        cnt_in_range_s;
  logic        load_we_s;
  logic        run_s;

  // ---------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------
  logic [15:0]       mem_r [RAM_WORDS];
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [15:0]       ram_wdata_s;
  logic [15:0]       rdata_r;

  // ---------------------------------------------------------------------
  // OUT capture FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic [7:0]       head_next_s;
  logic             out_valid_r;
  logic [7:0]       out_data_r;
  logic             ovf_r;

  logic             push_req_s;
  logic             pop_s;
  logic             full_s;
  logic             push_s;
  logic             drop_s;

  // Upper address bits are intentionally ignored so the RAM aliases.
  if (ADDR_W < 16) begin : g_alias
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^address[15:ADDR_W];
  end

  assign run_s       = (state_r == ST_RUN);
  assign byte_take_s = ld_valid & ld_ready_r;
  // Words past the end of the RAM are consumed but never written.
  assign cnt_in_range_s = ({1'b0, cnt_r} < 17'(RAM_WORDS));

  // Load sequencer: length high/low, then hi/lo byte pairs per word.
  always_comb begin
    state_next_s = state_r;
    len_next_s   = len_r;
    held_next_s  = held_r;
    cnt_next_s   = cnt_r;
    load_we_s    = 1'b0;
    case (state_r)
      ST_LEN_HI: begin
        if (byte_take_s) begin
          len_next_s   = {ld_byte, len_r[7:0]};
          state_next_s = ST_LEN_LO;
        end else begin
          state_next_s = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (byte_take_s) begin
          len_next_s = {len_r[15:8], ld_byte};
          if ({len_r[15:8], ld_byte} == 16'd0) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_DAT_HI;
          end
        end else begin
          state_next_s = ST_LEN_LO;
        end
      end
      ST_DAT_HI: begin
        if (byte_take_s) begin
          held_next_s  = ld_byte;
          state_next_s = ST_DAT_LO;
        end else begin
          state_next_s = ST_DAT_HI;
        end
      end
      ST_DAT_LO: begin
        if (byte_take_s) begin
          load_we_s  = cnt_in_range_s;
          cnt_next_s = cnt_r + 16'd1;
          if ((cnt_r + 16'd1) == len_r) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_DAT_HI;
          end
        end else begin
          state_next_s = ST_DAT_LO;
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
      end
      default: begin
        state_next_s = ST_LEN_HI;
      end
    endcase
  end

  // Sequencer registers plus the registered handshake/run outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_LEN_HI;
      len_r      <= 16'd0;
      held_r     <= 8'd0;
      cnt_r      <= 16'd0;
      ld_ready_r <= 1'b0;
      cpu_run_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      len_r      <= len_next_s;
      held_r     <= held_next_s;
      cnt_r      <= cnt_next_s;
      ld_ready_r <= (state_next_s != ST_RUN);
      cpu_run_r  <= (state_next_s == ST_RUN);
    end
  end

  // Single RAM write port: loader owns it before RUN, the CPU after.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = address[ADDR_W-1:0];
    ram_wdata_s = wdata;
    if (rst) begin
      ram_we_s = 1'b0;
    end else if (run_s) begin
      ram_we_s    = wr;
      ram_waddr_s = address[ADDR_W-1:0];
      ram_wdata_s = wdata;
    end else begin
      ram_we_s    = load_we_s;
      ram_waddr_s = cnt_r[ADDR_W-1:0];
      ram_wdata_s = {held_r, ld_byte};
    end
  end

  // RAM storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Registered read port; old data on a same-address write (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 16'd0;
    end else if (run_s) begin
      rdata_r <= mem_r[address[ADDR_W-1:0]];
    end else begin
      rdata_r <= 16'd0;
    end
  end

  // FIFO handshake decode; a full FIFO still accepts a push that coincides with a pop.
  assign push_req_s = run_s & lr;
  assign pop_s      = out_valid_r & out_ready;
  assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;

  // FIFO next pointers, occupancy and the head that will be visible next cycle.
  always_comb begin
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    // A byte written this edge lands at the new head only when it is the sole entry.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = leds;
    end else begin
      head_next_s = fifo_r[rd_ptr_next_s];
    end
  end

  // FIFO storage (no reset needed, only read behind valid occupancy).
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= leds;
    end
  end

  // FIFO pointers, registered head/valid view and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      ovf_r       <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != '0);
      out_data_r  <= (count_next_s != '0) ? head_next_s : 8'd0;
      ovf_r       <= ovf_r | drop_s;
    end
  end

  assign rdata        = rdata_r;
  assign ld_ready     = ld_ready_r;
  assign cpu_run      = cpu_run_r;
  assign out_data     = out_data_r;
  assign out_valid    = out_valid_r;
  assign out_overflow = ovf_r;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with a stream-level reference model
// checked every cycle plus hand-computed expectations at key points.

module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        wr;
  logic [15:0] rdata;
  logic [7:0]  leds;
  logic        lr;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        cpu_run;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_bus_responder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .address(address), .wdata(wdata), .wr(wr), .rdata(rdata),
    .leds(leds), .lr(lr),
    .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .cpu_run(cpu_run),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (stream/queue level) ----------------
  bit          m_armed = 1'b0;
  bit          m_run;
  bit          m_ready;
  int          m_nb;          // stream bytes accepted since reset
  logic [15:0] m_len;
  logic [7:0]  m_held;
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] m_rdata;
  bit          m_rdata_known;
  logic [7:0]  m_q [$];
  bit          m_ovf;

  task automatic model_compare();
    if (m_armed) begin
      check("m_ld_ready", {15'd0, ld_ready}, {15'd0, m_ready});
      check("m_cpu_run", {15'd0, cpu_run}, {15'd0, m_run});
      check("m_out_valid", {15'd0, out_valid}, {15'd0, (m_q.size() > 0)});
      check("m_out_overflow", {15'd0, out_overflow}, {15'd0, m_ovf});
      if (m_rdata_known) check("m_rdata", rdata, m_rdata);
      if (m_q.size() > 0) check("m_out_data", {8'd0, out_data}, {8'd0, m_q[0]});
    end
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_armed = 1'b1; m_run = 1'b0; m_ready = 1'b0; m_nb = 0;
      m_len = 16'd0; m_held = 8'd0; m_rdata = 16'd0; m_rdata_known = 1'b1;
      m_q.delete(); m_ovf = 1'b0;
    end else if (m_armed && m_run) begin
      m_rdata       = m_mem[address[7:0]];
      m_rdata_known = m_known[address[7:0]];
      if (wr) begin
        m_mem[address[7:0]]   = wdata;
        m_known[address[7:0]] = 1'b1;
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (lr) begin
        if (m_q.size() < 4) m_q.push_back(leds);
        else m_ovf = 1'b1;
      end
      m_ready = 1'b0;
    end else if (m_armed) begin
      if (ld_valid && m_ready) begin
        if (m_nb == 0) m_len[15:8] = ld_byte;
        else if (m_nb == 1) m_len[7:0] = ld_byte;
        else begin
          w = (m_nb - 2) / 2;
          if ((m_nb % 2) == 0) m_held = ld_byte;
          else if (w < 256) begin
            m_mem[w]   = {m_held, ld_byte};
            m_known[w] = 1'b1;
          end
        end
        m_nb++;
        if (m_nb >= 2 && m_nb == 2 + 2 * int'(m_len)) m_run = 1'b1;
      end
      m_rdata = 16'd0; m_rdata_known = 1'b1;
      m_ready = !m_run;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_compare();
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    ld_byte  = b;
    ld_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = ld_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: byte %h not accepted, ld_ready=%b", b, ld_ready);
    end
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic read_word(input logic [15:0] a, input logic [15:0] exp, input string name);
    address = a; wr = 1'b0;
    tick();
    check(name, rdata, exp);
  endtask

  logic [7:0] boot0 [8];
  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];

  initial begin
    rst = 1'b1; address = 16'd0; wdata = 16'd0; wr = 1'b0;
    leds = 8'd0; lr = 1'b0; ld_byte = 8'd0; ld_valid = 1'b0; out_ready = 1'b0;
    boot0 = '{8'h00, 8'h03, 8'h80, 8'h05, 8'h80, 8'h03, 8'h08, 8'h00};
    exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_b = '{8'h22, 8'h33, 8'h44, 8'h66};

    // Reset values
    do_reset();
    check("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("rst_cpu_run", {15'd0, cpu_run}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", {8'd0, out_data}, 16'd0);
    check("rst_overflow", {15'd0, out_overflow}, 16'd0);
    check("rst_rdata", rdata, 16'd0);
    tick();
    check("ld_ready_after_rst", {15'd0, ld_ready}, 16'd1);

    // Boot load: len=3, words 8005 8003 0800
    for (int i = 0; i < 8; i++) begin
      send_byte(boot0[i]);
      if (i == 6) check("run_before_last", {15'd0, cpu_run}, 16'd0);
    end
    check("load_cpu_run", {15'd0, cpu_run}, 16'd1);
    check("load_ld_ready", {15'd0, ld_ready}, 16'd0);

    // Bus reads, including aliasing
    read_word(16'h0001, 16'h8003, "read_w1");
    read_word(16'h0101, 16'h8003, "read_alias");
    read_word(16'h0000, 16'h8005, "read_w0");
    read_word(16'h0002, 16'h0800, "read_w2");

    // Read-before-write on word 5
    address = 16'h0005; wr = 1'b1; wdata = 16'h1234;
    tick();
    wdata = 16'hBEEF;
    tick();
    check("rbw_old", rdata, 16'h1234);
    wr = 1'b0;
    tick();
    check("rbw_new", rdata, 16'hBEEF);

    // FIFO fill to overflow with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      leds = 8'h11 * 8'(i + 1); lr = 1'b1;
      tick();
    end
    lr = 1'b0;
    check("fifo_valid", {15'd0, out_valid}, 16'd1);
    check("fifo_ovf", {15'd0, out_overflow}, 16'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fifo_drain", {8'd0, out_data}, {8'd0, exp_a[k]});
      tick();
    end
    check("fifo_empty", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      leds = exp_a[i]; lr = 1'b1;
      tick();
    end
    check("full_head", {8'd0, out_data}, 16'h0011);
    leds = 8'h66; lr = 1'b1; out_ready = 1'b1;
    tick();
    lr = 1'b0;
    check("pushpop_ovf", {15'd0, out_overflow}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      check("pushpop_drain", {8'd0, out_data}, {8'd0, exp_b[k]});
      tick();
    end
    check("pushpop_empty", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b0;

    // Leave something queued, then reset and start a 4-word load
    leds = 8'h77; lr = 1'b1;
    tick();
    lr = 1'b0;
    check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    do_reset();
    check("rst2_cpu_run", {15'd0, cpu_run}, 16'd0);
    check("rst2_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst2_overflow", {15'd0, out_overflow}, 16'd0);
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2);
    send_byte(8'hB1); send_byte(8'hB2);
    check("midload_not_run", {15'd0, cpu_run}, 16'd0);

    // Abandon the load; a fresh len=0 load must run immediately
    do_reset();
    check("rst3_cpu_run", {15'd0, cpu_run}, 16'd0);
    check("rst3_ld_ready", {15'd0, ld_ready}, 16'd0);
    send_byte(8'h00); send_byte(8'h00);
    check("len0_cpu_run", {15'd0, cpu_run}, 16'd1);
    read_word(16'h0000, 16'hA1A2, "keep_w0");
    read_word(16'h0001, 16'hB1B2, "keep_w1");
    read_word(16'h0002, 16'h0800, "keep_w2");
    read_word(16'h0005, 16'hBEEF, "keep_w5");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Slave-side companion to the stack CPU. It answers the CPU's word-addressed memory bus (address, data_out, wr out of the CPU; data_in back into it) from an internal single-port word RAM.
- Before the CPU is released, it loads that RAM from a byte-stream boot port.
- It captures the CPU's OUT strobes (LEDS/Lr) into a small FIFO that drains over a valid/ready output port.
- It sits between the CPU and the board top level and gates CPU execution with cpu_run.

Parameters:
- ADDR_W, 8, RAM word-address width; RAM holds 2**ADDR_W 16-bit words.
- FIFO_DEPTH, 4, OUT-capture FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  16  CPU word address; bits [ADDR_W-1:0] used, upper bits ignored (aliasing).
- wdata  in  16  CPU write data (CPU data_out).
- wr  in  1  CPU write strobe.
- rdata  out  16  read data to CPU data_in.
- leds  in  8  CPU LEDS value.
- lr  in  1  CPU OUT strobe, one cycle per OUT.
- ld_byte  in  8  boot stream byte.
- ld_valid  in  1  boot byte valid.
- ld_ready  out  1  boot byte accepted when ld_valid & ld_ready.
- cpu_run  out  1  high once load completes; the top level holds the CPU idle while low.
- out_data  out  8  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- out_overflow  out  1  sticky: an OUT was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - Outputs: rdata=0, ld_ready=0, cpu_run=0, out_valid=0, out_data=0, out_overflow=0.
  - Internal: FIFO empty, state=LEN_HI, word counter=0.
  - RAM contents are NOT cleared by reset.
- Reset mid-load or mid-run: abandons the operation, returns to LEN_HI. RAM keeps whatever was written.
- ld_ready is high in the cycle after reset deasserts and stays high in all load states. It is 0 while rst is high and in RUN.
- Load FSM (a byte is consumed only when ld_valid & ld_ready):
  - LEN_HI: capture len[15:8] -> LEN_LO.
  - LEN_LO: capture len[7:0]. If len==0 -> RUN, else -> DAT_HI.
  - DAT_HI: hold the byte as word[15:8] -> DAT_LO.
  - DAT_LO: write {held, byte} to mem[counter], counter+1. If counter+1==len -> RUN, else -> DAT_HI.
  - Words with counter >= 2**ADDR_W are accepted but not written (no wrap).
  - RUN: cpu_run=1 from the first cycle in RUN and stays high until reset.
- Bus response (RUN only):
  - Every cycle, rdata <= mem[address[ADDR_W-1:0]]: one-cycle registered read latency.
  - If wr=1, mem[address] <= wdata in the same edge.
  - Read and write to the same address in one cycle returns the OLD data (read-before-write).
  - Outside RUN, rdata is held at 0 and wr is ignored.
- OUT capture (RUN only; lr outside RUN ignored):
  - Push: lr=1 pushes leds.
  - Pop: out_valid & out_ready pops the head.
  - out_data/out_valid are registered views of the head and count; the head updates the cycle after a pop.
  - Empty FIFO: push makes out_valid=1 next cycle.
  - Simultaneous push and pop: count unchanged, allowed even when full.
  - Push when full without pop: the byte is dropped, out_overflow=1 (sticky until rst).
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then stream len=0x0003, words 0x8005,0x8003,0x0800 (bytes hi first) -> ld_ready drops and cpu_run rises the cycle after the 8th byte; mem[0..2] holds those words.
- In RUN, address=1 -> rdata=0x8003 one cycle later. address=0x0101 (ADDR_W=8) -> aliases to word 1, rdata=0x8003.
- wr=1, address=5, wdata=0xBEEF with a same-cycle read of 5 -> rdata returns old value. Next cycle read of 5 -> 0xBEEF.
- With out_ready=0, pulse lr with leds 0x11,0x22,0x33,0x44,0x55 -> out_valid=1, out_overflow=1. Raising out_ready then yields 0x11,0x22,0x33,0x44, then out_valid=0.
- FIFO full, lr=1 (leds=0x66) and out_ready=1 in the same cycle -> 0x11 popped, 0x66 enqueued, out_overflow unchanged.
- Assert rst after 2 of 4 data words -> cpu_run=0, FIFO empty, the FSM expects a new length, and the previously written words remain readable after a fresh len=0 load.
